// File: rtl/host_from_breakout_pkg.sv
// Shared constants, lane layout and state encoding for the breakout-link deserializer.
package host_from_breakout_pkg;

    localparam int FRAME_BITS = 10;
    localparam int PHASES     = 5;
    localparam int LANES      = 3;

    localparam logic [FRAME_BITS-1:0] FRAME_PATTERN = 10'b1111100000;
    localparam logic [2:0]            BLANK_CYCLES  = 3'd5;

    localparam int LANE_CLK = 0;
    localparam int LANE_D0  = 1;
    localparam int LANE_D1  = 2;

    // d0 window: {pad[1:0], button[5:0], link_pow[1:0]}
    localparam int D0_PAD_MSB = 9;
    localparam int D0_PAD_LSB = 8;
    localparam int D0_BTN_MSB = 7;
    localparam int D0_BTN_LSB = 2;
    localparam int D0_POW_MSB = 1;
    localparam int D0_POW_LSB = 0;

    // d1 window: {port[7:0], link_pow[3:2]}
    localparam int D1_PORT_MSB = 9;
    localparam int D1_PORT_LSB = 2;
    localparam int D1_POW_MSB  = 1;
    localparam int D1_POW_LSB  = 0;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    function automatic logic [FRAME_BITS-1:0] rotl_frame(input logic [FRAME_BITS-1:0] w,
                                                         input int n);
        logic [2*FRAME_BITS-1:0] t;
        t = {w, w} << n;
        return t[2*FRAME_BITS-1:FRAME_BITS];
    endfunction

    function automatic logic [2:0] phase_inc(input logic [2:0] p);
        return (p == 3'(PHASES - 1)) ? 3'd0 : p + 3'd1;
    endfunction

endpackage

// File: rtl/host_from_breakout_ddr_lane_slip.sv
// One lane of the DDR link: optional half-bit slip followed by the 10-bit shift window.
module ddr_lane_slip
    import host_from_breakout_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  slip_i,
    input  logic [1:0]            pair_i,
    output logic [FRAME_BITS-1:0] win_o
);

    logic                  prev_q;
    logic [1:0]            stream_pair;
    logic [FRAME_BITS-1:0] win_q;
    logic [FRAME_BITS-1:0] win_d;

    // With slip set, the late bit of the previous pair becomes the early bit of this one.
    assign stream_pair = slip_i ? {prev_q, pair_i[1]} : pair_i;
    assign win_d       = {win_q[FRAME_BITS-3:0], stream_pair};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q <= 1'b0;
            win_q  <= '0;
        end else begin
            prev_q <= pair_i[0];
            win_q  <= win_d;
        end
    end

    assign win_o = win_q;

endmodule

// File: rtl/host_from_breakout.sv
// Host-side breakout status deserializer: frame alignment from the clock lane, then field unpack.
module host_from_breakout
    import host_from_breakout_pkg::*;
#(
    parameter int LOCK_FRAMES   = 4,
    parameter int UNLOCK_FRAMES = 2,
    parameter int ERR_W         = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [1:0]       i_clk_s_pair,
    input  logic [1:0]       i_d0_pair,
    input  logic [1:0]       i_d1_pair,
    output logic [7:0]       o_port,
    output logic [5:0]       o_button,
    output logic [3:0]       o_link_pow,
    output logic             o_valid,
    output logic             o_locked,
    output logic             o_pad_err,
    output logic [ERR_W-1:0] o_err_count
);

    localparam int GW = $clog2(LOCK_FRAMES + 1);
    localparam int BW = $clog2(UNLOCK_FRAMES + 1);

    logic [1:0]            lane_pair [LANES];
    logic [FRAME_BITS-1:0] lane_win  [LANES];
    logic [FRAME_BITS-1:0] clk_win, d0_win, d1_win, exp_win;
    logic [PHASES-1:0]     even_hit, odd_hit;
    logic [2:0]            hit_phase;

    state_e           state_q, state_d;
    logic             slip_q, slip_d;
    logic [2:0]       blank_q, blank_d;
    logic [2:0]       phase_q, phase_d;
    logic [GW-1:0]    good_q, good_d;
    logic [BW-1:0]    bad_q, bad_d;
    logic [7:0]       port_q, port_d;
    logic [5:0]       button_q, button_d;
    logic [3:0]       pow_q, pow_d;
    logic             valid_q, valid_d;
    logic             pad_q, pad_d;
    logic [ERR_W-1:0] err_q, err_d;

    assign lane_pair[LANE_CLK] = i_clk_s_pair;
    assign lane_pair[LANE_D0]  = i_d0_pair;
    assign lane_pair[LANE_D1]  = i_d1_pair;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        ddr_lane_slip u_lane (
            .clk_i  (i_clk),
            .rst_ni (i_rst_n),
            .slip_i (slip_q),
            .pair_i (lane_pair[gi]),
            .win_o  (lane_win[gi])
        );
    end

    assign clk_win = lane_win[LANE_CLK];
    assign d0_win  = lane_win[LANE_D0];
    assign d1_win  = lane_win[LANE_D1];

    // Even rotations are reachable on pair boundaries; odd ones mean we are half a bit off.
    for (genvar gi = 0; gi < PHASES; gi++) begin : g_rot
        assign even_hit[gi] = (clk_win == rotl_frame(FRAME_PATTERN, 2 * gi));
        assign odd_hit[gi]  = (clk_win == rotl_frame(FRAME_PATTERN, 2 * gi + 1));
    end

    always_comb begin
        hit_phase = 3'd0;
        for (int i = 0; i < PHASES; i++) begin
            if (even_hit[i]) hit_phase = 3'(i);
        end
        exp_win = rotl_frame(FRAME_PATTERN, 2 * int'(phase_q));
    end

    always_comb begin
        state_d  = state_q;
        slip_d   = slip_q;
        blank_d  = blank_q;
        phase_d  = phase_inc(phase_q);
        good_d   = good_q;
        bad_d    = bad_q;
        port_d   = port_q;
        button_d = button_q;
        pow_d    = pow_q;
        valid_d  = 1'b0;
        pad_d    = pad_q;
        err_d    = err_q;

        unique case (state_q)
            ST_HUNT: begin
                if (blank_q != 3'd0) begin
                    blank_d = blank_q - 3'd1;
                end else if (|even_hit) begin
                    state_d = ST_CHECK;
                    phase_d = phase_inc(hit_phase);
                    good_d  = '0;
                end else if (|odd_hit) begin
                    slip_d  = ~slip_q;
                    blank_d = BLANK_CYCLES;
                end
            end
            ST_CHECK: begin
                if (clk_win != exp_win) begin
                    state_d = ST_HUNT;
                    blank_d = BLANK_CYCLES;
                end else if (phase_q == 3'd0) begin
                    if (good_q == GW'(LOCK_FRAMES - 1)) begin
                        state_d = ST_LOCKED;
                        bad_d   = '0;
                    end else begin
                        good_d = good_q + GW'(1);
                    end
                end
            end
            ST_LOCKED: begin
                if (phase_q == 3'd0) begin
                    if (clk_win == FRAME_PATTERN) begin
                        port_d   = d1_win[D1_PORT_MSB:D1_PORT_LSB];
                        button_d = d0_win[D0_BTN_MSB:D0_BTN_LSB];
                        pow_d    = {d1_win[D1_POW_MSB:D1_POW_LSB], d0_win[D0_POW_MSB:D0_POW_LSB]};
                        valid_d  = 1'b1;
                        pad_d    = pad_q | (d0_win[D0_PAD_MSB:D0_PAD_LSB] != 2'b00);
                        bad_d    = '0;
                    end else begin
                        if (err_q != {ERR_W{1'b1}}) err_d = err_q + ERR_W'(1);
                        if (bad_q == BW'(UNLOCK_FRAMES - 1)) begin
                            state_d = ST_HUNT;
                            blank_d = BLANK_CYCLES;
                            bad_d   = '0;
                        end else begin
                            bad_d = bad_q + BW'(1);
                        end
                    end
                end
            end
            default: begin
                state_d = ST_HUNT;
                blank_d = BLANK_CYCLES;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_HUNT;
            slip_q   <= 1'b0;
            blank_q  <= BLANK_CYCLES;
            phase_q  <= 3'd0;
            good_q   <= '0;
            bad_q    <= '0;
            port_q   <= '0;
            button_q <= '0;
            pow_q    <= '0;
            valid_q  <= 1'b0;
            pad_q    <= 1'b0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            slip_q   <= slip_d;
            blank_q  <= blank_d;
            phase_q  <= phase_d;
            good_q   <= good_d;
            bad_q    <= bad_d;
            port_q   <= port_d;
            button_q <= button_d;
            pow_q    <= pow_d;
            valid_q  <= valid_d;
            pad_q    <= pad_d;
            err_q    <= err_d;
        end
    end

    assign o_port      = port_q;
    assign o_button    = button_q;
    assign o_link_pow  = pow_q;
    assign o_valid     = valid_q;
    assign o_locked    = (state_q == ST_LOCKED);
    assign o_pad_err   = pad_q;
    assign o_err_count = err_q;

endmodule

// File: tb/tb_host_from_breakout.sv
// Bench for host_from_breakout: frame-level transmitter model plus scoreboard on every o_valid.
module tb_host_from_breakout;

    localparam int NF = 512;
    localparam logic [9:0] CLK_IDEAL = 10'b1111100000;
    localparam logic [9:0] CLK_BAD   = 10'b1010101010;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] cs_pair = 2'b00, d0_pair = 2'b00, d1_pair = 2'b00;

    logic [7:0]  o_port,  s_port;
    logic [5:0]  o_button, s_button;
    logic [3:0]  o_pow,   s_pow;
    logic        o_valid, s_valid, o_locked, s_locked, o_pad, s_pad;
    logic [15:0] o_err;
    logic [1:0]  s_err;

    always #5 clk = ~clk;

    host_from_breakout dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_clk_s_pair(cs_pair), .i_d0_pair(d0_pair),
        .i_d1_pair(d1_pair), .o_port(o_port), .o_button(o_button), .o_link_pow(o_pow),
        .o_valid(o_valid), .o_locked(o_locked), .o_pad_err(o_pad), .o_err_count(o_err)
    );

    host_from_breakout #(.ERR_W(2)) dut_sat (
        .i_clk(clk), .i_rst_n(rst_n), .i_clk_s_pair(cs_pair), .i_d0_pair(d0_pair),
        .i_d1_pair(d1_pair), .o_port(s_port), .o_button(s_button), .o_link_pow(s_pow),
        .o_valid(s_valid), .o_locked(s_locked), .o_pad_err(s_pad), .o_err_count(s_err)
    );

    // Transmitted frames of the current stream
    logic [7:0] f_port [NF];
    logic [5:0] f_btn  [NF];
    logic [3:0] f_pow  [NF];
    logic [1:0] f_pad  [NF];
    bit         f_bad  [NF];

    int  k_delay, cyc, checks, errors, last_valid, nvalid, lock_at;
    bit  gap_chk, exp_pad;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bit g of a lane's serial stream (g=0 is the first half-bit after reset release).
    function automatic logic lane_bit(input int lane, input int g);
        int j, f, pos;
        logic [9:0] w;
        j   = g - k_delay;
        f   = (j >= 0) ? j / 10 : -((9 - j) / 10);
        pos = j - 10 * f;
        w   = CLK_IDEAL;
        if (lane == 0) begin
            if (f >= 0 && f < NF && f_bad[f]) w = CLK_BAD;
        end else if (f < 0 || f >= NF) begin
            w = '0;
        end else if (lane == 1) begin
            w = {f_pad[f], f_btn[f], f_pow[f][1:0]};
        end else begin
            w = {f_port[f], f_pow[f][3:2]};
        end
        return w[9 - pos];
    endfunction

    function automatic int frame_end_cycle(input int f);
        return (10 * f + k_delay + 9) / 2;
    endfunction

    function automatic int end_frame(input int c);
        int j;
        for (int g = 2 * c; g <= 2 * c + 1; g++) begin
            j = g - k_delay - 9;
            if (j >= 0 && j % 10 == 0) return j / 10;
        end
        return -1;
    endfunction

    function automatic int first_after(input int c);
        int f = 0;
        while (frame_end_cycle(f) <= c) f++;
        return f;
    endfunction

    task automatic tick();
        int fe;
        bit ok;
        cs_pair = {lane_bit(0, 2 * cyc), lane_bit(0, 2 * cyc + 1)};
        d0_pair = {lane_bit(1, 2 * cyc), lane_bit(1, 2 * cyc + 1)};
        d1_pair = {lane_bit(2, 2 * cyc), lane_bit(2, 2 * cyc + 1)};
        @(posedge clk);
        #1;
        if (o_valid) begin
            fe = end_frame(cyc - 1);
            ok = (fe >= 0 && fe < NF) ? !f_bad[fe] : 1'b0;
            check("vld_src", ok, 1);
            if (ok) begin
                check("vld_port", o_port, f_port[fe]);
                check("vld_button", o_button, f_btn[fe]);
                check("vld_pow", o_pow, f_pow[fe]);
                if (f_pad[fe] != 2'b00) exp_pad = 1'b1;
                check("vld_pad", o_pad, exp_pad);
            end
            if (gap_chk && last_valid >= 0) check("vld_gap", cyc - last_valid, 5);
            $display("edge %0d frame %0d port=%h button=%h pow=%h", cyc, fe, o_port, o_button, o_pow);
            last_valid = cyc;
            nvalid++;
        end
        cyc++;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic wait_lock(input string tag, input int bound);
        lock_at = -1;
        for (int i = 0; i < bound; i++) begin
            tick();
            if (o_locked) begin
                lock_at = cyc - 1;
                break;
            end
        end
        check(tag, (lock_at >= 0), 1);
        $display("%s: lock at edge %0d (delay %0d half-bits)", tag, lock_at, k_delay);
    endtask

    task automatic start_seg(input int k, input bit fixed);
        rst_n   = 1'b0;
        k_delay = k;
        for (int f = 0; f < NF; f++) begin
            f_port[f] = fixed ? 8'hA5 : 8'($urandom_range(0, 255));
            f_btn[f]  = fixed ? 6'h2C : 6'($urandom_range(0, 63));
            f_pow[f]  = fixed ? 4'h9  : 4'($urandom_range(0, 15));
            f_pad[f]  = 2'b00;
            f_bad[f]  = 1'b0;
        end
        cyc = 0; exp_pad = 1'b0; last_valid = -1; gap_chk = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_outs", {o_port, o_button, o_pow, o_valid, o_locked, o_pad, o_err}, 64'd0);
        check("rst_sat", {s_port, s_button, s_pow, s_valid, s_locked, s_pad, s_err}, 64'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        int fb, ce, base;
        checks = 0; errors = 0; nvalid = 0;

        // Aligned, constant-content stream
        start_seg(0, 1'b1);
        wait_lock("A_lock30", 30);
        gap_chk = 1'b1;
        run(10);
        nvalid = 0;
        run(50);
        check("A_nvalid", nvalid, 10);
        check("A_port", o_port, 8'hA5);
        check("A_button", o_button, 6'h2C);
        check("A_pow", o_pow, 4'h9);
        check("A_err", o_err, 0);
        check("A_pad", o_pad, 0);

        // One half-bit late
        start_seg(1, 1'b0);
        wait_lock("B_lock", 60);
        gap_chk = 1'b1;
        run(10);
        nvalid = 0;
        run(25);
        check("B_nvalid", nvalid, 5);
        check("B_err", o_err, 0);

        // Three half-bits late; the later steps keep using this stream
        start_seg(3, 1'b0);
        wait_lock("C_lock", 60);
        gap_chk = 1'b1;
        run(10);
        nvalid = 0;
        run(25);
        check("C_nvalid", nvalid, 5);

        // Single corrupted frame while locked
        gap_chk = 1'b0;
        fb = first_after(cyc + 5);
        f_bad[fb] = 1'b1;
        ce = frame_end_cycle(fb);
        while (cyc <= ce + 1) tick();
        check("D_err", o_err, 1);
        check("D_locked", o_locked, 1);
        check("D_novalid", o_valid, 0);
        check("D_hold", {o_port, o_button, o_pow}, {f_port[fb - 1], f_btn[fb - 1], f_pow[fb - 1]});
        run(10);

        // Two consecutive corrupted frames drop lock
        fb = first_after(cyc + 5);
        f_bad[fb] = 1'b1;
        f_bad[fb + 1] = 1'b1;
        ce = frame_end_cycle(fb + 1);
        while (cyc <= ce + 1) tick();
        check("E_unlock", o_locked, 0);
        check("E_err", o_err, 3);
        nvalid = 0;
        run(10);
        check("E_novalid", nvalid, 0);
        wait_lock("E_relock", 60);
        last_valid = -1;
        gap_chk = 1'b1;
        run(20);
        check("E_err_hold", o_err, 3);

        // Pad bits set in one frame; flag is sticky
        fb = first_after(cyc + 5);
        f_pad[fb] = 2'b10;
        ce = frame_end_cycle(fb);
        while (cyc <= ce + 1) tick();
        check("F_pad", o_pad, 1);
        run(30);
        check("F_pad_sticky", o_pad, 1);

        // Asynchronous reset in the middle of a frame
        run(2);
        #2;
        rst_n = 1'b0;
        #1;
        check("G_rst_outs", {o_port, o_button, o_pow, o_valid, o_locked, o_pad, o_err}, 64'd0);
        check("G_rst_sat", {s_port, s_button, s_pow, s_valid, s_locked, s_pad, s_err}, 64'd0);
        gap_chk = 1'b0;
        run(2);
        rst_n = 1'b1;
        exp_pad = 1'b0;
        last_valid = -1;
        wait_lock("G_relock", 60);
        run(20);
        check("G_err", o_err, 0);
        check("G_pad", o_pad, 0);

        // Five isolated bad frames: exact count vs two-bit saturating count
        start_seg(0, 1'b0);
        wait_lock("H_lock", 30);
        base = first_after(cyc + 5);
        for (int i = 0; i < 5; i++) f_bad[base + 3 * i] = 1'b1;
        ce = frame_end_cycle(base + 12);
        while (cyc <= ce + 1) tick();
        check("H_err_wide", o_err, 5);
        check("H_err_sat", s_err, 3);
        check("H_locked", o_locked, 1);
        check("H_locked_sat", s_locked, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
